// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core: multiply/divide op codes, FSM states
// and the default datapath width.
package mips_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    // Bit 1 of the op selects divide, bit 0 selects the unsigned variant.
    function automatic logic md_is_div(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input logic [1:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/md_iter_core.sv
// Unsigned iterative datapath: one shift-add multiply or restoring
// shift-subtract divide step per enabled cycle over WIDTH steps.
module md_iter_core
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo
);

    // acc holds the upper product half or the partial remainder; shreg
    // holds the shifting multiplier/dividend that becomes lower half/quotient.
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] opb;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   trial;

    always_comb begin
        add_sum = {1'b0, acc} + (shreg[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        trial   = {acc, shreg[WIDTH-1]} - {1'b0, opb};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            shreg <= '0;
            opb   <= '0;
        end else if (load) begin
            acc   <= '0;
            shreg <= op_a;
            opb   <= op_b;
        end else if (step) begin
            if (is_div) begin
                // trial[WIDTH] set means the subtraction borrowed: restore.
                if (!trial[WIDTH]) begin
                    acc   <= trial[WIDTH-1:0];
                    shreg <= {shreg[WIDTH-2:0], 1'b1};
                end else begin
                    acc   <= {acc[WIDTH-2:0], shreg[WIDTH-1]};
                    shreg <= {shreg[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc   <= add_sum[WIDTH:1];
                shreg <= {add_sum[0], shreg[WIDTH-1:1]};
            end
        end
    end

    assign res_hi = acc;
    assign res_lo = shreg;

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO; raises Busy_MD as a
// stall request while an operation is in flight.
module mult_div_unit
    import mips_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             Start_E,
    input  logic [1:0]       Op_E,
    input  logic [WIDTH-1:0] Src_A_E,
    input  logic [WIDTH-1:0] Src_B_E,
    input  logic             Flush_E,
    input  logic             Write_Hi_W,
    input  logic             Write_Lo_W,
    input  logic [WIDTH-1:0] Write_Data_W,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Busy_MD,
    output logic             Done_MD
);

    localparam int CW = $clog2(WIDTH + 1);

    md_state_e        state, next_state;
    logic [CW-1:0]    count;
    logic             load, step, commit;
    logic             is_div_q, neg_main_q, neg_rem_q, div_zero_q;
    logic [WIDTH-1:0] orig_a_q;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             sign_a, sign_b;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH-1:0] fix_hi, fix_lo;
    logic [2*WIDTH-1:0] product;

    // Signed ops hand magnitudes to the core; signs are reapplied in FIX.
    always_comb begin
        sign_a = md_is_signed(Op_E) & Src_A_E[WIDTH-1];
        sign_b = md_is_signed(Op_E) & Src_B_E[WIDTH-1];
        mag_a  = sign_a ? -Src_A_E : Src_A_E;
        mag_b  = sign_b ? -Src_B_E : Src_B_E;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MD_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        step       = 1'b0;
        commit     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (Start_E && !Flush_E) begin
                    load       = 1'b1;
                    next_state = MD_CALC;
                end
            end
            MD_CALC: begin
                step = 1'b1;
                if (count == CW'(1)) begin
                    next_state = MD_FIX;
                end
            end
            MD_FIX: begin
                commit     = 1'b1;
                next_state = MD_IDLE;
            end
            default: next_state = MD_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count      <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div_zero_q <= 1'b0;
            orig_a_q   <= '0;
        end else if (load) begin
            count      <= CW'(WIDTH);
            is_div_q   <= md_is_div(Op_E);
            neg_main_q <= sign_a ^ sign_b;
            neg_rem_q  <= sign_a;
            div_zero_q <= (Src_B_E == '0);
            orig_a_q   <= Src_A_E;
        end else if (step) begin
            count <= count - CW'(1);
        end
    end

    md_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .step   (step),
        .is_div (is_div_q),
        .op_a   (mag_a),
        .op_b   (mag_b),
        .res_hi (res_hi),
        .res_lo (res_lo)
    );

    // A zero divisor bypasses sign fixup so HI returns the raw dividend.
    always_comb begin
        product = {res_hi, res_lo};
        if (neg_main_q) begin
            product = -product;
        end
        fix_hi = product[2*WIDTH-1:WIDTH];
        fix_lo = product[WIDTH-1:0];
        if (is_div_q) begin
            if (div_zero_q) begin
                fix_hi = orig_a_q;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem_q  ? -res_hi : res_hi;
                fix_lo = neg_main_q ? -res_lo : res_lo;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Hi      <= '0;
            Lo      <= '0;
            Done_MD <= 1'b0;
        end else begin
            Done_MD <= 1'b0;
            if (commit) begin
                Hi      <= fix_hi;
                Lo      <= fix_lo;
                Done_MD <= 1'b1;
            end else if (state == MD_IDLE) begin
                if (Write_Hi_W) begin
                    Hi <= Write_Data_W;
                end
                if (Write_Lo_W) begin
                    Lo <= Write_Data_W;
                end
            end
        end
    end

    assign Busy_MD = (state != MD_IDLE);

endmodule
